// File: rtl/count_step_decoder.sv
// count_step_decoder: watches the sampled output of an up/down counter and
// recovers the step command (enable, direction) behind each new sample.
// Illegal jumps are flagged and counted; lock is regained after LOCK_N
// consecutive legal deltas. All step outputs are registered.
module count_step_decoder #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned RUN_W  = 8,
    parameter int unsigned ERR_W  = 8,
    parameter int unsigned LOCK_N = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             count_valid,
    input  logic [WIDTH-1:0] count,
    input  logic             clear_err,
    output logic             step_valid,
    output logic             step_en,
    output logic             step_up,
    output logic             step_err,
    output logic             locked,
    output logic [RUN_W-1:0] run_len,
    output logic [ERR_W-1:0] err_cnt,
    output logic             err_seen
);

    typedef enum logic [1:0] {StUnlocked, StLocked, StHold} state_e;
    typedef enum logic [1:0] {ClsIdle, ClsUp, ClsDown, ClsErr} class_e;

    localparam logic [3:0]       LockN  = 4'(LOCK_N);
    localparam logic [WIDTH-1:0] DeltaUp = WIDTH'(1);

    state_e           state_q, state_d;
    logic [3:0]       good_q, good_d;
    logic [WIDTH-1:0] prev_q;

    logic             step_valid_q, step_en_q, step_up_q, step_err_q;
    class_e           class_q, cls;
    logic [RUN_W-1:0] run_len_q, run_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d, err_base;
    logic             err_seen_q, err_seen_d;

    logic [WIDTH-1:0] delta;
    logic             d_en, d_up, d_err;
    logic             decode_fire;

    // Classify the modular delta between this sample and the reference
    always_comb begin
        delta = count - prev_q;
        d_en  = 1'b0;
        d_up  = 1'b0;
        d_err = 1'b0;
        cls   = ClsIdle;
        if (delta == '0) begin
            cls = ClsIdle;
        end else if (delta == DeltaUp) begin
            d_en = 1'b1;
            d_up = 1'b1;
            cls  = ClsUp;
        end else if (delta == '1) begin
            d_en = 1'b1;
            cls  = ClsDown;
        end else begin
            d_err = 1'b1;
            cls   = ClsErr;
        end
    end

    // The very first sample after reset only seeds the reference
    assign decode_fire = count_valid && (state_q != StUnlocked);

    // FSM state register plus lock counter and reference sample
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q <= StUnlocked;
            good_q  <= '0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            if (count_valid) begin
                prev_q <= count;  // resync even on illegal jumps
            end
        end
    end

    // FSM next state: drop lock on an illegal delta, regain after LOCK_N good ones
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        if (count_valid) begin
            unique case (state_q)
                StUnlocked: state_d = StLocked;
                StLocked: begin
                    if (d_err) begin
                        state_d = StHold;
                        good_d  = '0;
                    end
                end
                StHold: begin
                    if (d_err) begin
                        good_d = '0;
                    end else if (good_q + 4'd1 == LockN) begin
                        state_d = StLocked;
                        good_d  = '0;
                    end else begin
                        good_d = good_q + 4'd1;
                    end
                end
                default: begin
                    state_d = StUnlocked;
                    good_d  = '0;
                end
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        locked = (state_q == StLocked);
    end

    // Next run length and error bookkeeping
    always_comb begin
        if (d_err) begin
            run_d = '0;
        end else if (cls != class_q) begin
            run_d = RUN_W'(1);
        end else if (run_len_q == '1) begin
            run_d = run_len_q;
        end else begin
            run_d = run_len_q + RUN_W'(1);
        end

        // A new error in the same cycle as clear_err still counts as one
        err_base   = clear_err ? '0 : err_cnt_q;
        err_cnt_d  = err_base;
        err_seen_d = clear_err ? 1'b0 : err_seen_q;
        if (decode_fire && d_err) begin
            err_seen_d = 1'b1;
            if (err_base != '1) begin
                err_cnt_d = err_base + ERR_W'(1);
            end
        end
    end

    // Registered step outputs; fields hold between decoded samples
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            step_valid_q <= 1'b0;
            step_en_q    <= 1'b0;
            step_up_q    <= 1'b0;
            step_err_q   <= 1'b0;
            // Error class makes the first decoded legal sample a class change
            class_q      <= ClsErr;
            run_len_q    <= '0;
            err_cnt_q    <= '0;
            err_seen_q   <= 1'b0;
        end else begin
            step_valid_q <= decode_fire;
            if (decode_fire) begin
                step_en_q  <= d_en;
                step_up_q  <= d_up;
                step_err_q <= d_err;
                class_q    <= cls;
                run_len_q  <= run_d;
            end
            err_cnt_q  <= err_cnt_d;
            err_seen_q <= err_seen_d;
        end
    end

    // Drive ports from the registered step state
    always_comb begin
        step_valid = step_valid_q;
        step_en    = step_en_q;
        step_up    = step_up_q;
        step_err   = step_err_q;
        run_len    = run_len_q;
        err_cnt    = err_cnt_q;
        err_seen   = err_seen_q;
    end

endmodule

// File: tb/tb_count_step_decoder.sv
// Directed bench for count_step_decoder: expected step fields are queued as each
// sample is driven and popped when the decoder strobes step_valid.
module tb_count_step_decoder;

    logic       clk;
    logic       reset_n;
    logic       count_valid;
    logic [3:0] count;
    logic       clear_err;
    logic       step_valid, step_en, step_up, step_err, locked, err_seen;
    logic [7:0] run_len, err_cnt;

    typedef struct packed {
        logic en;
        logic up;
        logic err;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    count_step_decoder #(
        .WIDTH (4),
        .RUN_W (8),
        .ERR_W (8),
        .LOCK_N(2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .count_valid(count_valid),
        .count      (count),
        .clear_err  (clear_err),
        .step_valid (step_valid),
        .step_en    (step_en),
        .step_up    (step_up),
        .step_err   (step_err),
        .locked     (locked),
        .run_len    (run_len),
        .err_cnt    (err_cnt),
        .err_seen   (err_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, step_valid, 0);
        chk({tag, "_en"}, step_en, 0);
        chk({tag, "_up"}, step_up, 0);
        chk({tag, "_err"}, step_err, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_run"}, run_len, 0);
        chk({tag, "_errcnt"}, err_cnt, 0);
        chk({tag, "_seen"}, err_seen, 0);
    endtask

    // Drive one valid sample and check the registered result one edge later
    task automatic sample(input logic [3:0] c, input logic clr, input logic strobe,
                          input logic en, input logic up, input logic err, input logic lk,
                          input int rl, input int ec, input logic seen);
        exp_t e;
        if (strobe) begin
            e.en  = en;
            e.up  = up;
            e.err = err;
            sb_q.push_back(e);
        end
        @(negedge clk);
        count_valid = 1'b1;
        count       = c;
        clear_err   = clr;
        @(posedge clk);
        #1;
        count_valid = 1'b0;
        clear_err   = 1'b0;
        chk("strobe", step_valid, strobe);
        if (step_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("step_en", step_en, e.en);
                chk("step_up", step_up, e.up);
                chk("step_err", step_err, e.err);
            end
        end else begin
            sb_q.delete();
        end
        chk("locked", locked, lk);
        chk("run_len", run_len, rl);
        chk("err_cnt", err_cnt, ec);
        chk("err_seen", err_seen, seen);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            count_valid = 1'b0;
            @(posedge clk);
            #1;
            chk("gap_strobe", step_valid, 0);
        end
    endtask

    // Assert reset away from the clock edge and confirm outputs clear at once
    task automatic pulse_reset(input string tag);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        #1;
        chk_all_zero(tag);
        @(negedge clk);
        reset_n = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b1;
        count_valid = 1'b0;
        count       = '0;
        clear_err   = 1'b0;
        #1;
        chk_all_zero("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;

        // Reference then three up steps
        sample(4'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        sample(4'd1, 0, 1, 1, 1, 0, 1, 1, 0, 0);
        sample(4'd2, 0, 1, 1, 1, 0, 1, 2, 0, 0);
        sample(4'd3, 0, 1, 1, 1, 0, 1, 3, 0, 0);

        // Wrap-around up, idle, wrap-around down
        pulse_reset("rst_a");
        sample(4'd14, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        sample(4'd15, 0, 1, 1, 1, 0, 1, 1, 0, 0);
        sample(4'd0,  0, 1, 1, 1, 0, 1, 2, 0, 0);
        sample(4'd1,  0, 1, 1, 1, 0, 1, 3, 0, 0);
        sample(4'd1,  0, 1, 0, 0, 0, 1, 1, 0, 0);
        sample(4'd0,  0, 1, 1, 0, 0, 1, 1, 0, 0);
        sample(4'd15, 0, 1, 1, 0, 0, 1, 2, 0, 0);

        // Illegal jump, relock after two good deltas, interrupted relock
        pulse_reset("rst_b");
        sample(4'd4,  0, 0, 0, 0, 0, 1, 0, 0, 0);
        sample(4'd5,  0, 1, 1, 1, 0, 1, 1, 0, 0);
        sample(4'd9,  0, 1, 0, 0, 1, 0, 0, 1, 1);
        sample(4'd10, 0, 1, 1, 1, 0, 0, 1, 1, 1);
        sample(4'd11, 0, 1, 1, 1, 0, 1, 2, 1, 1);
        sample(4'd15, 0, 1, 0, 0, 1, 0, 0, 2, 1);
        sample(4'd0,  0, 1, 1, 1, 0, 0, 1, 2, 1);
        sample(4'd13, 0, 1, 0, 0, 1, 0, 0, 3, 1);
        sample(4'd14, 0, 1, 1, 1, 0, 0, 1, 3, 1);
        sample(4'd15, 0, 1, 1, 1, 0, 1, 2, 3, 1);

        // clear_err on its own
        @(negedge clk);
        clear_err = 1'b1;
        @(posedge clk);
        #1;
        clear_err = 1'b0;
        chk("clr_errcnt", err_cnt, 0);
        chk("clr_seen", err_seen, 0);
        chk("clr_strobe", step_valid, 0);
        chk("clr_locked", locked, 1);

        // clear_err coincident with an illegal delta: the new error survives
        sample(4'd4, 1, 1, 0, 0, 1, 0, 0, 1, 1);
        sample(4'd5, 0, 1, 1, 1, 0, 0, 1, 1, 1);
        sample(4'd6, 0, 1, 1, 1, 0, 1, 2, 1, 1);

        // Gap between samples yields exactly one step
        pulse_reset("rst_c");
        sample(4'd3, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        gap(4);
        sample(4'd4, 0, 1, 1, 1, 0, 1, 1, 0, 0);
        sample(4'd3, 0, 1, 1, 0, 0, 1, 1, 0, 0);
        sample(4'd2, 0, 1, 1, 0, 0, 1, 2, 0, 0);

        // Reset between samples: next sample is only a reference
        gap(1);
        pulse_reset("rst_mid");
        sample(4'd7, 0, 0, 0, 0, 0, 1, 0, 0, 0);

        // run_len saturates on a long idle run
        for (int i = 0; i < 260; i++) begin
            sample(4'd7, 0, 1, 0, 0, 0, 1, (i + 1 > 255) ? 255 : i + 1, 0, 0);
        end

        // err_cnt saturates on a long stream of illegal jumps
        for (int i = 0; i < 260; i++) begin
            sample((i % 2 == 1) ? 4'd8 : 4'd0, 0, 1, 0, 0, 1, 0, 0,
                   (i + 1 > 255) ? 255 : i + 1, 1);
        end
        sample(4'd9,  1, 1, 1, 1, 0, 0, 1, 0, 0);
        sample(4'd10, 0, 1, 1, 1, 0, 1, 2, 0, 0);

        chk("sb_drain", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/count_step_decoder.md
Name: count_step_decoder

Overview:
- Decodes the output trajectory of the 4-bit up/down counter back into the step commands that produced it.
- Per sample, recovers enable/up_down by comparing against the previous sample, and flags illegal jumps.
- Tracks lock state, run length and error count.
- Sits downstream of the counter as its protocol monitor/decoder in self-checking subsystems.

Parameters:
- WIDTH, 4, count width; legal range WIDTH >= 2.
- RUN_W, 8, width of run-length output; saturating.
- ERR_W, 8, width of error counter; saturating.
- LOCK_N, 2, consecutive legal deltas required to regain lock after an error; range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-high reset (asserted when 1).
- count_valid  input  1  count is a sample this cycle.
- count  input  WIDTH  sampled counter value.
- clear_err  input  1  synchronous clear of err_cnt and err_seen.
- step_valid  output  1  one-cycle strobe; decoded step fields are valid.
- step_en  output  1  decoded enable (1 = counter moved).
- step_up  output  1  decoded up_down (1 = up); 0 when step_en = 0.
- step_err  output  1  decoded delta was illegal; qualified by step_valid.
- locked  output  1  decoder trusts its reference.
- run_len  output  RUN_W  consecutive legal samples of the current class.
- err_cnt  output  ERR_W  illegal deltas seen; saturating.
- err_seen  output  1  sticky: any error since reset/clear.

Behaviour:
- Reset (async, reset_n = 1): state = UNLOCKED, prev = 0, good_cnt = 0. All outputs are 0.
- States:
  - UNLOCKED: first valid sample only loads prev. No step_valid. Next state is LOCKED.
  - LOCKED: decodes every valid sample.
  - HOLD: decodes every valid sample but locked = 0.
- Delta: d = (count - prev) mod 2^WIDTH.
  - d = 0 -> en = 0, up = 0.
  - d = 1 -> en = 1, up = 1.
  - d = 2^WIDTH-1 -> en = 1, up = 0.
  - Any other d -> err = 1, en = 0, up = 0.
- Wrap-around is legal: 15->0 decodes as up; 0->15 decodes as down.
- Latency: outputs for a sample appear the cycle after count_valid, registered. step_valid is a single-cycle pulse per decoded sample.
- prev <= count on every valid sample, including illegal ones (resync to latest value).
- LOCKED + illegal d -> HOLD. locked drops on the same edge step_err is presented; good_cnt = 0.
- HOLD + legal d -> good_cnt + 1. On reaching LOCK_N -> LOCKED, locked = 1 on the same edge. An illegal d in HOLD resets good_cnt to 0.
- Classes: idle, up, down, err.
  - run_len = 1 on the first decoded sample or on a class change; otherwise +1, saturating at 2^RUN_W-1.
  - err class sets run_len = 0.
  - Updates with step_valid; holds otherwise.
- err_cnt: +1 per illegal d, saturating at 2^ERR_W-1. err_seen = 1 on any illegal d.
- clear_err alone: err_cnt = 0, err_seen = 0 next edge.
- clear_err in the same cycle an illegal result registers: err_cnt = 1, err_seen = 1 (new error wins).
- Gaps (count_valid = 0) do not alter prev, state or run_len; outputs other than step_valid hold.
- Reset mid-run: immediate return to UNLOCKED. The first post-reset sample is a reference only, never an error.

Test Plan:
- Reset, then samples 0,1,2,3 -> first sample gives no step_valid. Then three strobes en = 1, up = 1, run_len 1,2,3; locked = 1 from cycle after the first sample.
- Samples 14,15,0,1 then 1,0,15 -> up wraps legal. Then idle (en = 0, run_len 1), then down ×2, run_len 1,2 after the class change. err_cnt = 0.
- LOCKED at 5, sample 9 -> step_err = 1, locked = 0, err_cnt = 1, err_seen = 1. Then 10,11 -> locked = 1 after the second legal sample (LOCK_N = 2). A 13 between them instead -> err_cnt = 2, stays unlocked.
- Samples 3, gap of 4 cycles, 4 -> exactly two... one decoded up step. No strobes during the gap.
- clear_err with err_cnt = 3 and no error -> err_cnt = 0, err_seen = 0. clear_err coincident with illegal result -> err_cnt = 1.
- Assert reset_n mid-stream between valid samples -> all outputs 0 asynchronously. The next sample, e.g. 7 after 2, produces no error and no strobe.
